dcache_refill_ctrl: RTL and testbench

//  Sequences the single main-memory port behind the MEM-stage data cache.
//  On a load miss it stalls the pipeline, fetches the whole line word-by-word
//  and writes it into the cache. On every store it issues one write-through.
//  Its stall output feeds the hazard unit, which freezes the F/D/E/M stages.

---
 rtl/dcache_refill_ctrl.sv | 132 +++++++++++++
 tb/tb_dcache_refill_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_refill_ctrl.sv
// Data-cache refill/write-through sequencer for the single main-memory port.
// A load miss fetches the whole line word by word; each store becomes one write.
module dcache_refill_ctrl #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDRESS_WIDTH  = 32,
  parameter int WORDS_PER_LINE = 4,
  localparam int IDX_W         = $clog2(WORDS_PER_LINE)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     lookup_valid,
  input  logic                     lookup_is_load,
  input  logic [ADDRESS_WIDTH-1:0] lookup_addr,
  input  logic [DATA_WIDTH-1:0]    lookup_wdata,
  input  logic                     cache_hit,
  output logic                     stall,
  output logic                     mem_req_valid,
  input  logic                     mem_req_ready,
  output logic                     mem_req_we,
  output logic [ADDRESS_WIDTH-1:0] mem_req_addr,
  output logic [DATA_WIDTH-1:0]    mem_req_wdata,
  input  logic                     mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0]    mem_rsp_data,
  output logic                     fill_we,
  output logic [IDX_W-1:0]         fill_idx,
  output logic [DATA_WIDTH-1:0]    fill_data,
  output logic                     fill_done
);

  localparam int BYTES      = DATA_WIDTH / 8;
  localparam int WORD_SHIFT = $clog2(BYTES);
  localparam int LINE_SHIFT = $clog2(WORDS_PER_LINE * BYTES);
  localparam logic [ADDRESS_WIDTH-1:0] LINE_MASK = {ADDRESS_WIDTH{1'b1}} << LINE_SHIFT;
  localparam logic [ADDRESS_WIDTH-1:0] WORD_MASK = {ADDRESS_WIDTH{1'b1}} << WORD_SHIFT;

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, DONE} state_t;

  state_t                   state;
  logic [IDX_W-1:0]         cnt;
  logic [ADDRESS_WIDTH-1:0] line_base;
  logic [ADDRESS_WIDTH-1:0] st_addr;
  logic [DATA_WIDTH-1:0]    st_data;
  logic                     refill;
  logic                     trigger;
  logic                     last_word;

  assign trigger   = lookup_valid & (~lookup_is_load | ~cache_hit);
  assign last_word = (cnt == IDX_W'(WORDS_PER_LINE - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      line_base <= '0;
      st_addr   <= '0;
      st_data   <= '0;
      refill    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (trigger) begin
            line_base <= lookup_addr & LINE_MASK;
            st_addr   <= lookup_addr & WORD_MASK;
            st_data   <= lookup_wdata;
            refill    <= lookup_is_load;
            state     <= lookup_is_load ? RD_REQ : WR_REQ;
          end
        end
        RD_REQ: if (mem_req_ready) state <= RD_WAIT;
        RD_WAIT: begin
          if (mem_rsp_valid) begin
            if (last_word) begin
              state <= DONE;
            end else begin
              cnt   <= cnt + 1'b1;
              state <= RD_REQ;
            end
          end
        end
        WR_REQ:  if (mem_req_ready) state <= WR_WAIT;
        WR_WAIT: if (mem_rsp_valid) state <= DONE;
        DONE: begin
          cnt    <= '0;
          refill <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs decode the registered state; only stall and fill_* also follow
  // same-cycle inputs. Reset gates the trigger term so everything reads 0.
  always_comb begin
    stall         = 1'b0;
    mem_req_valid = 1'b0;
    mem_req_we    = 1'b0;
    mem_req_addr  = '0;
    mem_req_wdata = '0;
    fill_we       = 1'b0;
    fill_idx      = '0;
    fill_data     = '0;
    fill_done     = 1'b0;
    case (state)
      IDLE: stall = rst & trigger;
      RD_REQ: begin
        stall         = 1'b1;
        mem_req_valid = 1'b1;
        mem_req_addr  = line_base + (ADDRESS_WIDTH'(cnt) << WORD_SHIFT);
      end
      RD_WAIT: begin
        stall = 1'b1;
        if (mem_rsp_valid) begin
          fill_we   = 1'b1;
          fill_idx  = cnt;
          fill_data = mem_rsp_data;
        end
      end
      WR_REQ: begin
        stall         = 1'b1;
        mem_req_valid = 1'b1;
        mem_req_we    = 1'b1;
        mem_req_addr  = st_addr;
        mem_req_wdata = st_data;
      end
      WR_WAIT: stall = 1'b1;
      DONE:    fill_done = refill;
      default: stall = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_dcache_refill_ctrl.sv
// Scoreboard bench for dcache_refill_ctrl: expected requests/fills are queued
// when a lookup is driven and popped as the DUT issues them.
module tb_dcache_refill_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        lookup_valid, lookup_is_load, cache_hit;
  logic [31:0] lookup_addr, lookup_wdata;
  logic        stall, mem_req_valid, mem_req_ready, mem_req_we;
  logic [31:0] mem_req_addr, mem_req_wdata;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        fill_we, fill_done;
  logic [1:0]  fill_idx;
  logic [31:0] fill_data;

  dcache_refill_ctrl #(.DATA_WIDTH(32), .ADDRESS_WIDTH(32), .WORDS_PER_LINE(4)) dut (
    .clk(clk), .rst(rst),
    .lookup_valid(lookup_valid), .lookup_is_load(lookup_is_load),
    .lookup_addr(lookup_addr), .lookup_wdata(lookup_wdata), .cache_hit(cache_hit),
    .stall(stall),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_we(mem_req_we),
    .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .fill_we(fill_we), .fill_idx(fill_idx), .fill_data(fill_data), .fill_done(fill_done)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; logic we; logic [31:0] wdata; } req_t;
  typedef struct { logic [1:0] idx; logic [31:0] data; } fill_t;

  req_t        exp_req_q[$];
  fill_t       exp_fill_q[$];
  logic [31:0] rsp_q[$];

  int unsigned n_tests = 0, n_fail = 0;
  int unsigned stall_cnt, done_cnt, req_seen;
  int          acc_cnt, hold_word, hold_left;
  logic        spur_en, last_stall;
  logic        hold_prev;
  logic [31:0] hold_addr;
  logic        hold_we;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_stall"}, stall, 0);
    check({tag, "_req_valid"}, mem_req_valid, 0);
    check({tag, "_req_we"}, mem_req_we, 0);
    check({tag, "_req_addr"}, mem_req_addr, 0);
    check({tag, "_req_wdata"}, mem_req_wdata, 0);
    check({tag, "_fill_we"}, fill_we, 0);
    check({tag, "_fill_idx"}, fill_idx, 0);
    check({tag, "_fill_data"}, fill_data, 0);
    check({tag, "_fill_done"}, fill_done, 0);
  endtask

  // One clock: sample/score at negedge, drive the memory model after posedge.
  task automatic tick();
    logic        rsp_next;
    logic [31:0] rsp_dnext;
    logic        spur_next;
    req_t        er;
    fill_t       ef;
    @(negedge clk);
    if (hold_prev) begin
      check("hold_valid", mem_req_valid, 1);
      check("hold_addr", mem_req_addr, hold_addr);
      check("hold_we", mem_req_we, hold_we);
    end
    hold_prev = mem_req_valid && !mem_req_ready;
    if (hold_prev) begin
      hold_addr = mem_req_addr;
      hold_we   = mem_req_we;
      if (hold_left > 0) hold_left--;
    end
    last_stall = stall;
    if (stall) stall_cnt++;
    if (fill_done) done_cnt++;
    if (mem_req_valid) req_seen++;
    rsp_next  = 1'b0;
    rsp_dnext = 32'h0;
    if (mem_req_valid && mem_req_ready) begin
      if (exp_req_q.size() == 0) begin
        check("req_extra", 1, 0);
      end else begin
        er = exp_req_q.pop_front();
        check("req_addr", mem_req_addr, er.addr);
        check("req_we", mem_req_we, er.we);
        if (er.we) check("req_wdata", mem_req_wdata, er.wdata);
      end
      rsp_next = 1'b1;
      if (!mem_req_we && rsp_q.size() > 0) rsp_dnext = rsp_q.pop_front();
      acc_cnt++;
    end
    if (fill_we) begin
      if (exp_fill_q.size() == 0) begin
        check("fill_extra", 1, 0);
      end else begin
        ef = exp_fill_q.pop_front();
        check("fill_idx", fill_idx, ef.idx);
        check("fill_data", fill_data, ef.data);
      end
    end
    spur_next = spur_en && hold_prev && (hold_left > 0);
    @(posedge clk);
    #1;
    mem_req_ready = !(hold_left > 0 && acc_cnt == hold_word);
    mem_rsp_valid = rsp_next | spur_next;
    mem_rsp_data  = rsp_next ? rsp_dnext : (spur_next ? 32'hBAD0BAD0 : 32'h0);
  endtask

  task automatic exp_load(input logic [31:0] a, input logic [31:0] d0);
    logic [31:0] base;
    base = a & ~32'hF;
    for (int i = 0; i < 4; i++) begin
      exp_req_q.push_back('{addr: base + 32'(i * 4), we: 1'b0, wdata: 32'h0});
      exp_fill_q.push_back('{idx: 2'(i), data: d0 + 32'(i)});
      rsp_q.push_back(d0 + 32'(i));
    end
  endtask

  task automatic run_txn(input string tag, input logic ld, input logic [31:0] a,
                         input logic [31:0] wd, input int unsigned stall_exp,
                         input int unsigned done_exp);
    int unsigned n;
    stall_cnt = 0; done_cnt = 0; acc_cnt = 0;
    lookup_valid = 1'b1; lookup_is_load = ld; lookup_addr = a;
    lookup_wdata = wd; cache_hit = 1'b0;
    tick();
    check({tag, "_stall_first"}, last_stall, 1);
    lookup_valid = 1'b0;
    n = 0;
    while (last_stall && n < 60) begin
      tick();
      n++;
    end
    check({tag, "_timeout"}, last_stall, 0);
    tick();
    tick();
    check({tag, "_stall_cycles"}, stall_cnt, stall_exp);
    check({tag, "_fill_done"}, done_cnt, done_exp);
    check({tag, "_req_left"}, exp_req_q.size(), 0);
    check({tag, "_fill_left"}, exp_fill_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned n;
    rst = 1'b0;
    lookup_valid = 1'b1; lookup_is_load = 1'b1; cache_hit = 1'b0;
    lookup_addr = 32'h1234; lookup_wdata = 32'h0;
    mem_req_ready = 1'b1; mem_rsp_valid = 1'b0; mem_rsp_data = 32'h0;
    hold_word = -1; hold_left = 0; spur_en = 1'b0; hold_prev = 1'b0;
    acc_cnt = 0; req_seen = 0; last_stall = 1'b0; stall_cnt = 0; done_cnt = 0;
    #1;
    check_zero("reset");
    repeat (2) @(posedge clk);
    #1;
    lookup_valid = 1'b0;
    rst = 1'b1;
    tick();

    // Load hit never touches memory.
    req_seen = 0;
    lookup_valid = 1'b1; lookup_is_load = 1'b1; cache_hit = 1'b1; lookup_addr = 32'h100;
    tick();
    check("hit_stall", last_stall, 0);
    repeat (3) tick();
    lookup_valid = 1'b0;
    tick();
    check("hit_no_req", req_seen, 0);

    // Full line refill, ready always high.
    exp_load(32'h1234, 32'hA0);
    run_txn("miss", 1'b1, 32'h1234, 32'h0, 9, 1);

    // Word 1 request held off by three not-ready cycles.
    hold_word = 1; hold_left = 3;
    exp_load(32'h5678, 32'h11);
    run_txn("backpressure", 1'b1, 32'h567C, 32'h0, 12, 1);
    hold_word = -1;

    // Write-through store.
    exp_req_q.push_back('{addr: 32'h2000, we: 1'b1, wdata: 32'hDEADBEEF});
    run_txn("store", 1'b0, 32'h2002, 32'hDEADBEEF, 3, 0);

    // Stray responses in IDLE and while a read request is pending.
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'h77;
    tick();
    check("spur_idle_stall", last_stall, 0);
    hold_word = 2; hold_left = 2; spur_en = 1'b1;
    exp_load(32'h3000, 32'h300);
    run_txn("spurious", 1'b1, 32'h3008, 32'h0, 11, 1);
    spur_en = 1'b0; hold_word = -1;

    // Reset in the middle of a refill.
    exp_load(32'h1234, 32'hC0);
    done_cnt = 0; stall_cnt = 0; acc_cnt = 0;
    lookup_valid = 1'b1; lookup_is_load = 1'b1; cache_hit = 1'b0; lookup_addr = 32'h1234;
    tick();
    lookup_valid = 1'b0;
    n = 0;
    while (exp_fill_q.size() > 2 && n < 40) begin
      tick();
      n++;
    end
    check("abort_progress", exp_fill_q.size(), 2);
    #2;
    lookup_valid = 1'b1;
    rst = 1'b0;
    #1;
    check_zero("abort");
    exp_req_q.delete(); exp_fill_q.delete(); rsp_q.delete();
    mem_rsp_valid = 1'b0; hold_prev = 1'b0;
    tick();
    tick();
    lookup_valid = 1'b0;
    check("abort_no_done", done_cnt, 0);
    rst = 1'b1;
    tick();
    exp_load(32'h40, 32'h400);
    run_txn("restart", 1'b1, 32'h40, 32'h0, 9, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
